rv_multicycle_ctrl: RTL and testbench
=====================================

// Module: rv_multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I subset core. Owns the PC and the instruction register (IR),
//  drives ir to the instruction decoder, and sequences FETCH/DECODE/EXEC/MEM/WB.
//  Handshakes with the instruction and data memories, gates register-file writes, applies taken branches.
//  Traps on illegal opcodes or memory timeouts.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded at reset
//  MEM_TIMEOUT  16             max wait cycles for imem_ready/dmem_ready; 0 disables the timeout
//  TW           8              width of the wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk            in   1   single core clock, all state on rising edge
//  rst_n          in   1   synchronous, active-low reset
//  imem_req       out  1   instruction fetch request
//  imem_addr      out  32  fetch address (= pc)
//  imem_ready     in   1   fetch data valid this cycle
//  imem_rdata     in   32  fetched instruction
//  ir             out  32  latched instruction, to the decoder
//  branch_taken   in   1   ALU compare result for the branch in ir (valid in EXEC)
//  branch_target  in   32  pc + B-immediate from the datapath (valid in EXEC)
//  dmem_req       out  1   data access request
//  dmem_we        out  1   1 = store, 0 = load (meaningful only with dmem_req)
//  dmem_ready     in   1   data access complete this cycle
//  rf_we          out  1   register-file write strobe
//  rf_wsel        out  1   writeback source: 0 = ALU result, 1 = load data
//  pc             out  32  current PC
//  instret        out  32  retired-instruction counter
//  trap           out  1   sticky trap flag
//  trap_cause     out  2   00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
// BEHAVIOUR
//  - Reset state (rst_n = 0 at a clock edge):
//    state = IDLE, pc = RESET_PC, ir = 32'h0000_0013 (NOP), instret = 0, trap = 0, trap_cause = 00.
//    All strobes (imem_req, dmem_req, dmem_we, rf_we, rf_wsel) = 0.
//  - Reset mid-operation aborts any pending request the same edge; no retire is counted.
//  - Strobes decode from state only (Moore); no combinational path from imem_ready or dmem_ready to them.
//  - States and transitions:
//    IDLE   -> FETCH unconditionally.
//    FETCH  imem_req = 1, held until imem_ready. On ready: ir <= imem_rdata; -> DECODE.
//    DECODE classify ir[6:0]:
//           0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH -> EXEC.
//           Any other opcode -> TRAP, cause 01.
//    EXEC   R/I -> WB. LOAD/STORE -> MEM.
//           BRANCH: pc <= branch_taken ? branch_target : pc+4; retire; -> FETCH.
//    MEM    dmem_req = 1, dmem_we = (class == STORE), held until dmem_ready.
//           On ready: LOAD -> WB; STORE: pc <= pc+4; retire; -> FETCH.
//    WB     rf_we = 1 for exactly one cycle; rf_wsel = (class == LOAD).
//           pc <= pc+4; retire; -> FETCH.
//    TRAP   absorbing until reset; all strobes 0; pc, ir, instret frozen.
//  - Latency with zero-wait memory (ready in the first request cycle), in cycles:
//    R/I 4, LOAD 5, STORE 4, BRANCH 3. Each extra wait cycle adds 1.
//  - Wait counter: cleared on entry to FETCH/MEM; increments each cycle req=1 and ready=0.
//    When it reaches MEM_TIMEOUT with ready still 0 -> TRAP, cause 10 (FETCH) or 11 (MEM).
//    A ready arriving in the same cycle the count reaches MEM_TIMEOUT wins: no trap.
//  - PC arithmetic is mod 2^32: pc = FFFF_FFFC + 4 -> 0000_0000.
//  - instret increments once per retire, wraps FFFF_FFFF -> 0. Trapped instructions do not retire.
//  - The instruction class is registered in DECODE; ir is stable from DECODE until the next FETCH completes.
// STRUCTURE
//  Shared package rv_pkg holds:
//  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
//  - the state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP);
//  - the instruction-class and trap-cause codes; the NOP constant.
//  Sub-module rv_mem_wait_timer (clear, count_en, ready -> expired) holds the timeout counter.
// TESTING
//  1 Reset: hold rst_n = 0 for 3 cycles -> pc = 0, ir = 0x00000013, all strobes 0.
//    Release -> imem_req = 1 two cycles later.
//  2 ADDI x1,x0,5 (0x00500093) with zero-wait imem -> rf_we=1, rf_wsel=0 in cycle 4 only;
//    pc 0 -> 4; instret = 1.
//  3 LW (0x00002083) with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 cycles;
//    rf_we with rf_wsel=1; total 8 cycles.
//  4 BEQ at pc=0x10, branch_taken=1, target=0x40 -> pc=0x40 after 3 cycles, no rf_we;
//    same with branch_taken=0 -> pc=0x14.
//  5 Opcode 0x0000007F -> trap=1, cause 01 after DECODE; imem_req stays 0 for 20 cycles;
//    instret unchanged.
//  6 imem_ready held 0 with MEM_TIMEOUT=16 -> trap, cause 10, after 16 wait cycles.
//    Repeat with ready on exactly the 16th wait cycle -> no trap.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I multi-cycle core: opcodes, sequencer
// states, instruction classes, trap causes and the reset instruction.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0,x0,0 -- what ir holds until the first fetch completes
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } iclass_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM_TO = 2'b10,
        CAUSE_DMEM_TO = 2'b11
    } trap_cause_t;

    // Map a major opcode onto the class the sequencer cares about.
    function automatic iclass_t classify(input logic [6:0] opcode);
        iclass_t cls;
        case (opcode)
            OP_R:      cls = CLS_R;
            OP_I:      cls = CLS_I;
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            default:   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv_mem_wait_timer.sv
// Counts wait cycles of an outstanding memory request and flags a timeout
// once MEM_TIMEOUT waits have elapsed with ready still low. A ready in the
// cycle the limit is reached takes priority, so expired stays low then.
module rv_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TW          = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT);

    logic [TW-1:0] count;

    // Wait-cycle counter: cleared on entry to a request state, saturating.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && !ready && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && count_en && !ready && (count == LIMIT);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I subset core. Owns pc, ir and the
// retired-instruction counter, walks FETCH/DECODE/EXEC/MEM/WB and parks in
// TRAP on an illegal opcode or a memory timeout. All strobes are Moore
// outputs decoded from the registered state and instruction class.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16,
    parameter int          TW          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    state_t      state, state_nxt;
    iclass_t     cls, cls_nxt;
    trap_cause_t cause, cause_nxt;
    logic [31:0] pc_nxt, ir_nxt, instret_nxt;
    logic [31:0] pc_plus4;
    logic        retire;

    logic        tmr_clear, tmr_en, tmr_ready, tmr_expired;

    assign pc_plus4 = pc + 32'd4;

    // Only one of the two request states is ever active, so the timer
    // watches whichever ready belongs to the current request.
    assign tmr_en    = (state == FETCH) || (state == MEM);
    assign tmr_ready = (state == FETCH) ? imem_ready : dmem_ready;
    assign tmr_clear = (state_nxt != state) && ((state_nxt == FETCH) || (state_nxt == MEM));

    rv_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TW          (TW)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .count_en (tmr_en),
        .ready    (tmr_ready),
        .expired  (tmr_expired)
    );

    // Next-state, next-pc, ir capture, class capture and retire decision.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_nxt   = state;
        cls_nxt     = cls;
        cause_nxt   = cause;
        pc_nxt      = pc;
        ir_nxt      = ir;
        retire      = 1'b0;

        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = DECODE;
                end else if (tmr_expired) begin
                    cause_nxt = CAUSE_IMEM_TO;
                    state_nxt = TRAP;
                end
            end
            DECODE: begin
                cls_nxt = classify(ir[6:0]);
                if (cls_nxt == CLS_ILLEGAL) begin
                    cause_nxt = CAUSE_ILLEGAL;
                    state_nxt = TRAP;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (cls)
                    CLS_BRANCH: begin
                        pc_nxt    = branch_taken ? branch_target : pc_plus4;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_nxt = MEM;
                    default:             state_nxt = WB;
                endcase
            end
            MEM: begin
                if (dmem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_nxt    = pc_plus4;
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (tmr_expired) begin
                    cause_nxt = CAUSE_DMEM_TO;
                    state_nxt = TRAP;
                end
            end
            WB: begin
                pc_nxt    = pc_plus4;
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            TRAP: begin
                state_nxt = TRAP;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        instret_nxt = retire ? (instret + 32'd1) : instret;
    end

    // Architectural and sequencer registers; reset aborts any request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cls     <= CLS_R;
            cause   <= CAUSE_NONE;
            pc      <= RESET_PC;
            ir      <= NOP;
            instret <= '0;
        end else begin
            state   <= state_nxt;
            cls     <= cls_nxt;
            cause   <= cause_nxt;
            pc      <= pc_nxt;
            ir      <= ir_nxt;
            instret <= instret_nxt;
        end
    end

    // Moore strobes: decoded from registered state/class only.
    always_comb begin
        imem_req = (state == FETCH);
        dmem_req = (state == MEM);
        dmem_we  = (state == MEM) && (cls == CLS_STORE);
        rf_we    = (state == WB);
        rf_wsel  = (state == WB) && (cls == CLS_LOAD);
    end

    assign imem_addr  = pc;
    assign trap       = (state == TRAP);
    assign trap_cause = cause;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: reset values, per-class latency and
// strobes, branches, pc wrap, illegal-opcode trap, fetch/data timeouts and
// the ready-at-limit boundary. Inputs change and outputs are sampled on the
// falling edge; the design acts on the rising edge.
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        rf_we;
    logic        rf_wsel;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the last run_instr call
    int r_cycles, r_we_n, r_we_cyc, r_dcyc;
    logic r_wsel, r_dwe;

    rv_multicycle_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .MEM_TIMEOUT (16),
        .TW          (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ir            (ir),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ready    (dmem_ready),
        .rf_we         (rf_we),
        .rf_wsel       (rf_wsel),
        .pc            (pc),
        .instret       (instret),
        .trap          (trap),
        .trap_cause    (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one instruction starting in FETCH. imem/dmem answer after iw/dw
    // wait cycles. Ends when the next fetch starts or the core traps.
    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic taken, input logic [31:0] target);
        int  f_cnt = 0;
        int  d_cnt = 0;
        bit  left  = 1'b0;
        r_cycles = -1; r_we_n = 0; r_we_cyc = 0; r_dcyc = 0;
        r_wsel = 1'b0; r_dwe = 1'b0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            imem_rdata    = instr;
            branch_taken  = taken;
            branch_target = target;
            imem_ready    = imem_req && (f_cnt >= iw);
            dmem_ready    = dmem_req && (d_cnt >= dw);
            if (imem_req) f_cnt++; else left = 1'b1;
            if (dmem_req) begin
                d_cnt++;
                r_dcyc++;
                if (dmem_we) r_dwe = 1'b1;
            end
            if (rf_we) begin
                r_we_n++;
                r_we_cyc = cyc;
                r_wsel   = rf_wsel;
            end
            step();
            if (trap || (imem_req && left)) begin
                r_cycles = cyc;
                break;
            end
        end
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int req_seen;
        logic [31:0] pc_hold, ins_hold;

        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; branch_taken = 1'b0;
        branch_target = '0; dmem_ready = 1'b0;
        @(negedge clk);

        // 1: reset values
        do_reset(3);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0000_0013);
        check("rst_instret", instret, 32'h0);
        check("rst_strobes", {imem_req, dmem_req, dmem_we, rf_we, rf_wsel}, 32'h0);
        check("rst_trap", {trap, trap_cause}, 32'h0);
        rst_n = 1'b1;
        step();
        check("rel_imem_req", imem_req, 32'h1);
        check("rel_imem_addr", imem_addr, 32'h0);

        // 2: ADDI, zero-wait
        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0);
        check("addi_cycles", r_cycles, 32'd4);
        check("addi_we_n", r_we_n, 32'd1);
        check("addi_we_cyc", r_we_cyc, 32'd4);
        check("addi_wsel", r_wsel, 32'h0);
        check("addi_ir", ir, 32'h0050_0093);
        check("addi_pc", pc, 32'h4);
        check("addi_instret", instret, 32'd1);

        // 3: LW with 3 data wait cycles
        run_instr(32'h0000_2083, 0, 3, 1'b0, 32'h0);
        check("lw_cycles", r_cycles, 32'd8);
        check("lw_dcyc", r_dcyc, 32'd4);
        check("lw_dwe", r_dwe, 32'h0);
        check("lw_we_cyc", r_we_cyc, 32'd8);
        check("lw_wsel", r_wsel, 32'h1);
        check("lw_pc", pc, 32'h8);
        check("lw_instret", instret, 32'd2);

        // STORE, zero-wait: 4 cycles, no register write
        run_instr(32'h0010_2023, 0, 0, 1'b0, 32'h0);
        check("sw_cycles", r_cycles, 32'd4);
        check("sw_dcyc", r_dcyc, 32'd1);
        check("sw_dwe", r_dwe, 32'h1);
        check("sw_we_n", r_we_n, 32'd0);
        check("sw_pc", pc, 32'hC);
        check("sw_instret", instret, 32'd3);

        // R-type with 2 fetch wait cycles
        run_instr(32'h0020_81B3, 2, 0, 1'b0, 32'h0);
        check("add_cycles", r_cycles, 32'd6);
        check("add_we_cyc", r_we_cyc, 32'd6);
        check("add_pc", pc, 32'h10);
        check("add_instret", instret, 32'd4);

        // 4: BEQ taken at 0x10 -> 0x40
        run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h40);
        check("beq_t_cycles", r_cycles, 32'd3);
        check("beq_t_we_n", r_we_n, 32'd0);
        check("beq_t_pc", pc, 32'h40);
        check("beq_t_addr", imem_addr, 32'h40);
        check("beq_t_instret", instret, 32'd5);

        // back to 0x10, then BEQ not taken there -> 0x14
        run_instr(32'h0000_0063, 0, 0, 1'b1, 32'h10);
        check("beq_back_pc", pc, 32'h10);
        run_instr(32'h0000_0063, 0, 0, 1'b0, 32'h40);
        check("beq_nt_cycles", r_cycles, 32'd3);
        check("beq_nt_pc", pc, 32'h14);
        check("beq_nt_instret", instret, 32'd7);

        // pc wrap: branch to FFFF_FFFC, then ADDI there -> 0
        run_instr(32'h0000_0063, 0, 0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        run_instr(32'h0050_0093, 0, 0, 1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_instret", instret, 32'd9);

        // ready exactly when the fetch wait count reaches 16 wins
        run_instr(32'h0050_0093, 16, 0, 1'b0, 32'h0);
        check("ifb_cycles", r_cycles, 32'd20);
        check("ifb_trap", trap, 32'h0);
        check("ifb_pc", pc, 32'h4);

        // same boundary on the data side
        run_instr(32'h0000_2083, 0, 16, 1'b0, 32'h0);
        check("dfb_cycles", r_cycles, 32'd21);
        check("dfb_trap", trap, 32'h0);
        check("dfb_instret", instret, 32'd11);

        // 6: fetch never answers -> trap cause 10 after 16 wait cycles
        run_instr(32'h0050_0093, 1000, 0, 1'b0, 32'h0);
        check("ito_cycles", r_cycles, 32'd17);
        check("ito_trap", trap, 32'h1);
        check("ito_cause", trap_cause, 32'h2);
        check("ito_imem_req", imem_req, 32'h0);
        check("ito_instret", instret, 32'd11);
        check("ito_pc", pc, 32'h8);

        // reset out of trap
        do_reset(2);
        check("rst2_trap", {trap, trap_cause}, 32'h0);
        check("rst2_pc", pc, 32'h0);
        check("rst2_instret", instret, 32'h0);
        check("rst2_ir", ir, 32'h0000_0013);
        rst_n = 1'b1;
        step();

        // 5: illegal opcode
        run_instr(32'h0000_007F, 0, 0, 1'b0, 32'h0);
        check("ill_cycles", r_cycles, 32'd2);
        check("ill_trap", trap, 32'h1);
        check("ill_cause", trap_cause, 32'h1);
        check("ill_ir", ir, 32'h0000_007F);
        pc_hold  = pc;
        ins_hold = instret;
        req_seen = 0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req || dmem_req || rf_we) req_seen++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        check("ill_quiet", req_seen, 32'd0);
        check("ill_pc_frozen", pc, 32'h0);
        check("ill_instret", instret, 32'h0);
        check("ill_cause_hold", {trap, trap_cause}, 32'h5);
        if (pc_hold !== pc || ins_hold !== instret) begin
            n_checks++;
            n_fail++;
            $display("FAIL ill_frozen: pc %h instret %h moved", pc, instret);
        end

        // data access never completes -> trap cause 11
        do_reset(2);
        rst_n = 1'b1;
        step();
        run_instr(32'h0000_2083, 0, 1000, 1'b0, 32'h0);
        check("dto_cycles", r_cycles, 32'd20);
        check("dto_trap", trap, 32'h1);
        check("dto_cause", trap_cause, 32'h3);
        check("dto_dmem_req", dmem_req, 32'h0);
        check("dto_instret", instret, 32'h0);

        // reset while a data access is pending aborts it immediately
        do_reset(1);
        rst_n = 1'b1;
        step();
        run_instr(32'h0000_2083, 0, 1000, 1'b0, 32'h0);
        rst_n = 1'b0;
        step();
        check("abort_strobes", {imem_req, dmem_req, dmem_we, rf_we}, 32'h0);
        check("abort_instret", instret, 32'h0);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
